// File: rtl/counter_pkg.sv
// Package: counter_pkg
// Shared types for the mode counter and the FIR control logic that drives it.
// The end-of-range mode encoding lives here so every user decodes it the
// same way.

package counter_pkg;

    // End-of-range behaviour; the reserved code behaves like CNT_WRAP.
    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_SAT     = 2'd1,
        CNT_ONESHOT = 2'd2,
        CNT_RSVD    = 2'd3
    } cnt_mode_e;

    localparam int CNT_MODE_W = 2;

    // Map a raw mode code onto the enum, folding the reserved code into wrap.
    function automatic cnt_mode_e cnt_mode_decode(input logic [CNT_MODE_W-1:0] code);
        cnt_mode_e m;
        m = cnt_mode_e'(code);
        if (m == CNT_RSVD) begin
            m = CNT_WRAP;
        end
        return m;
    endfunction

endpackage

// File: rtl/count_prescaler.sv
// Module: count_prescaler
// Divides enabled cycles by PRESCALE: tick is high on the enabled cycle that
// completes a group of PRESCALE enabled cycles. The phase holds while en is
// low and returns to zero on rst or clr. Instantiated by mode_counter only
// when COUNT_PRESCALE_EN is defined.

module count_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] phase;

    assign tick = en && (phase == PS_LAST);

    // Phase counter: advances on enabled cycles, wraps after the tick cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            if (phase == PS_LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mode_counter.sv
// Module: mode_counter
// Up/down counter over 0..MAX_COUNT-1 with a runtime step and three
// end-of-range modes (wrap, saturate, one-shot), sync clear and parallel
// load. Drives tap/coef index and sample-pointer sequencing in the FIR.
// Optional feature macro: COUNT_PRESCALE_EN -- when defined, the counter
// steps once per PRESCALE enabled cycles through count_prescaler; when not
// defined every enabled cycle is a step and no prescaler logic exists.

module mode_counter
    import counter_pkg::*;
#(
    parameter int MAX_COUNT = 512,
    parameter int STEP_W    = 4,
    parameter int PRESCALE  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clr,
    input  logic                         load,
    input  logic [$clog2(MAX_COUNT)-1:0] load_val,
    input  logic                         up,
    input  logic [STEP_W-1:0]            step,
    input  logic [1:0]                   mode,
    output logic [$clog2(MAX_COUNT)-1:0] out,
    output logic                         tc,
    output logic                         wrap_pulse,
    output logic                         done
);

    localparam int CNT_W  = $clog2(MAX_COUNT);
    // One extra bit so out+step and out+MAX_COUNT-step never overflow.
    localparam int WIDE_W = CNT_W + 1;

    localparam logic [WIDE_W-1:0] MAX_WIDE  = WIDE_W'(MAX_COUNT);
    localparam logic [WIDE_W-1:0] LAST_WIDE = WIDE_W'(MAX_COUNT - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(MAX_COUNT - 1);

    // Parameter sanity: reject configurations the arithmetic cannot support.
    if (MAX_COUNT < 2) begin : g_bad_max_count
        $error("mode_counter: MAX_COUNT must be at least 2");
    end
    if ((2 ** STEP_W) - 1 >= MAX_COUNT) begin : g_bad_step_w
        $error("mode_counter: largest step must be below MAX_COUNT");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("mode_counter: PRESCALE must be at least 1");
    end

    // ------------------------------------------------------------------
    // Step strobe: either every enabled cycle or a prescaled tick.
    // ------------------------------------------------------------------
    logic step_en;

`ifdef COUNT_PRESCALE_EN
    logic ps_tick;

    count_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr | load),
        .en   (en),
        .tick (ps_tick)
    );

    assign step_en = ps_tick;
`else
    assign step_en = en;
`endif

    // ------------------------------------------------------------------
    // Next-state arithmetic
    // ------------------------------------------------------------------
    cnt_mode_e          cur_mode;
    logic [WIDE_W-1:0]  out_wide;
    logic [WIDE_W-1:0]  step_wide;
    logic [WIDE_W-1:0]  load_wide;
    logic [WIDE_W-1:0]  sum;
    logic [WIDE_W-1:0]  diff;
    logic [WIDE_W-1:0]  res;
    logic               overflow;
    logic               underflow;
    logic               do_step;
    logic [CNT_W-1:0]   nxt_out;
    logic               nxt_wrap;
    logic               nxt_done;

    // Combinational next value of out/wrap_pulse/done; clr > load > step.
    always_comb begin
        cur_mode  = cnt_mode_decode(mode);
        out_wide  = {1'b0, out};
        step_wide = WIDE_W'(step);
        load_wide = {1'b0, load_val};
        sum       = out_wide + step_wide;
        diff      = out_wide - step_wide;
        overflow  = (sum > LAST_WIDE);
        underflow = (step_wide > out_wide);
        // A finished one-shot ignores en until clr/load/rst; step 0 holds.
        do_step   = step_en && !done && (step != '0);
        res       = out_wide;
        nxt_wrap  = 1'b0;
        nxt_done  = done;

        if (clr) begin
            res      = '0;
            nxt_done = 1'b0;
        end else if (load) begin
            res      = (load_wide > LAST_WIDE) ? LAST_WIDE : load_wide;
            nxt_done = 1'b0;
        end else if (do_step) begin
            case (cur_mode)
                CNT_SAT: begin
                    if (up) begin
                        res = overflow ? LAST_WIDE : sum;
                    end else begin
                        res = underflow ? '0 : diff;
                    end
                end
                CNT_ONESHOT: begin
                    if (up) begin
                        if (sum >= LAST_WIDE) begin
                            res      = LAST_WIDE;
                            nxt_done = 1'b1;
                        end else begin
                            res = sum;
                        end
                    end else begin
                        if (step_wide >= out_wide) begin
                            res      = '0;
                            nxt_done = 1'b1;
                        end else begin
                            res = diff;
                        end
                    end
                end
                default: begin
                    if (up) begin
                        if (overflow) begin
                            res      = sum - MAX_WIDE;
                            nxt_wrap = 1'b1;
                        end else begin
                            res = sum;
                        end
                    end else begin
                        if (underflow) begin
                            res      = out_wide + MAX_WIDE - step_wide;
                            nxt_wrap = 1'b1;
                        end else begin
                            res = diff;
                        end
                    end
                end
            endcase
        end

        nxt_out = res[CNT_W-1:0];
    end

    // Count state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out        <= '0;
            wrap_pulse <= 1'b0;
            done       <= 1'b0;
        end else begin
            out        <= nxt_out;
            wrap_pulse <= nxt_wrap;
            done       <= nxt_done;
        end
    end

    // Terminal count follows direction only, regardless of mode.
    assign tc = up ? (out == LAST_CNT) : (out == '0);

endmodule

// File: tb/tb_mode_counter.sv
// Testbench for mode_counter with MAX_COUNT=10, STEP_W=3, PRESCALE=4.
// Directed scenarios with hand-computed expectations; the prescaler scenario
// is built only when COUNT_PRESCALE_EN is defined.

module tb_mode_counter;
    import counter_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       up;
    logic [2:0] step;
    logic [1:0] mode;
    logic [3:0] out;
    logic       tc;
    logic       wrap_pulse;
    logic       done;

    int n_checks;
    int n_errors;

    mode_counter #(
        .MAX_COUNT (10),
        .STEP_W    (3),
        .PRESCALE  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .load       (load),
        .load_val   (load_val),
        .up         (up),
        .step       (step),
        .mode       (mode),
        .out        (out),
        .tc         (tc),
        .wrap_pulse (wrap_pulse),
        .done       (done)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        up = 1'b1; step = 3'd0; mode = 2'(CNT_WRAP);
        clk_edge();
        clk_edge();
        n_checks++;
        if (out !== 4'd0 || wrap_pulse !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state out=%0d wp=%0b done=%0b exp out=0 wp=0 done=0", out, wrap_pulse, done);
        end
        n_checks++;
        if (tc !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_tc_up tc=%0b exp=0", tc);
        end
        up = 1'b0;
        #1;
        n_checks++;
        if (tc !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_tc_down tc=%0b exp=1", tc);
        end
        rst = 1'b0;
        up = 1'b1;
        clk_edge();
    endtask

    task automatic test_wrap_up;
        logic [3:0] exp_out[5] = '{4'd3, 4'd6, 4'd9, 4'd2, 4'd2};
        logic       exp_wp[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_tc[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        mode = 2'(CNT_WRAP); up = 1'b1; step = 3'd3; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) en = 1'b0;
            clk_edge();
            n_checks++;
            if (out !== exp_out[i] || wrap_pulse !== exp_wp[i] || tc !== exp_tc[i]) begin
                n_errors++;
                $display("FAIL wrap_up[%0d] out=%0d wp=%0b tc=%0b exp out=%0d wp=%0b tc=%0b",
                         i, out, wrap_pulse, tc, exp_out[i], exp_wp[i], exp_tc[i]);
            end
        end
    endtask

    task automatic test_sat_down;
        logic [3:0] exp_out[4] = '{4'd5, 4'd1, 4'd0, 4'd0};
        logic       exp_tc[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
        mode = 2'(CNT_SAT); up = 1'b0; step = 3'd4;
        load = 1'b1; load_val = 4'd9; en = 1'b0;
        clk_edge();
        load = 1'b0;
        n_checks++;
        if (out !== 4'd9) begin
            n_errors++;
            $display("FAIL sat_load out=%0d exp=9", out);
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clk_edge();
            n_checks++;
            if (out !== exp_out[i] || wrap_pulse !== 1'b0 || tc !== exp_tc[i]) begin
                n_errors++;
                $display("FAIL sat_down[%0d] out=%0d wp=%0b tc=%0b exp out=%0d wp=0 tc=%0b",
                         i, out, wrap_pulse, tc, exp_out[i], exp_tc[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_oneshot;
        mode = 2'(CNT_ONESHOT); up = 1'b1; step = 3'd1;
        load = 1'b1; load_val = 4'd7; en = 1'b0;
        clk_edge();
        load = 1'b0; en = 1'b1;
        clk_edge();
        n_checks++;
        if (out !== 4'd8 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL oneshot_8 out=%0d done=%0b exp out=8 done=0", out, done);
        end
        clk_edge();
        n_checks++;
        if (out !== 4'd9 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL oneshot_9 out=%0d done=%0b exp out=9 done=1", out, done);
        end
        clk_edge();
        n_checks++;
        if (out !== 4'd9 || done !== 1'b1 || wrap_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL oneshot_hold out=%0d done=%0b wp=%0b exp out=9 done=1 wp=0", out, done, wrap_pulse);
        end
        mode = 2'(CNT_WRAP);
        clk_edge();
        n_checks++;
        if (out !== 4'd9 || done !== 1'b1 || wrap_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL oneshot_mode_change out=%0d done=%0b wp=%0b exp out=9 done=1 wp=0", out, done, wrap_pulse);
        end
        clr = 1'b1;
        clk_edge();
        clr = 1'b0; en = 1'b0;
        n_checks++;
        if (out !== 4'd0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL oneshot_clr out=%0d done=%0b exp out=0 done=0", out, done);
        end
    endtask

    task automatic test_priority;
        mode = 2'(CNT_WRAP); up = 1'b1; step = 3'd1;
        load = 1'b1; en = 1'b1; load_val = 4'd15;
        clk_edge();
        n_checks++;
        if (out !== 4'd9 || wrap_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL load_clamp out=%0d wp=%0b exp out=9 wp=0", out, wrap_pulse);
        end
        load = 1'b0;
        clk_edge();
        n_checks++;
        if (out !== 4'd0 || wrap_pulse !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_9_to_0 out=%0d wp=%0b exp out=0 wp=1", out, wrap_pulse);
        end
        load = 1'b1; load_val = 4'd4;
        clk_edge();
        n_checks++;
        if (out !== 4'd4 || wrap_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL load_over_en out=%0d wp=%0b exp out=4 wp=0", out, wrap_pulse);
        end
        clr = 1'b1; load_val = 4'd5;
        clk_edge();
        n_checks++;
        if (out !== 4'd0) begin
            n_errors++;
            $display("FAIL clr_over_load out=%0d exp=0", out);
        end
        clr = 1'b0; load_val = 4'd4;
        clk_edge();
        load = 1'b0; step = 3'd0;
        for (int i = 0; i < 2; i++) begin
            clk_edge();
            n_checks++;
            if (out !== 4'd4 || wrap_pulse !== 1'b0) begin
                n_errors++;
                $display("FAIL step_zero[%0d] out=%0d wp=%0b exp out=4 wp=0", i, out, wrap_pulse);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_back_to_back;
        // Down-wrap then reserved mode acting as wrap, back to back.
        load = 1'b1; load_val = 4'd1;
        clk_edge();
        load = 1'b0; mode = 2'(CNT_WRAP); up = 1'b0; step = 3'd3; en = 1'b1;
        clk_edge();
        n_checks++;
        if (out !== 4'd8 || wrap_pulse !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_down out=%0d wp=%0b exp out=8 wp=1", out, wrap_pulse);
        end
        clk_edge();
        n_checks++;
        if (out !== 4'd5 || wrap_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_down_next out=%0d wp=%0b exp out=5 wp=0", out, wrap_pulse);
        end
        en = 1'b0; load = 1'b1; load_val = 4'd8;
        clk_edge();
        load = 1'b0; mode = 2'(CNT_RSVD); up = 1'b1; step = 3'd2; en = 1'b1;
        clk_edge();
        n_checks++;
        if (out !== 4'd0 || wrap_pulse !== 1'b1) begin
            n_errors++;
            $display("FAIL rsvd_wrap out=%0d wp=%0b exp out=0 wp=1", out, wrap_pulse);
        end
        clk_edge();
        n_checks++;
        if (out !== 4'd2 || wrap_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL rsvd_next out=%0d wp=%0b exp out=2 wp=0", out, wrap_pulse);
        end
        en = 1'b0;
    endtask

    task automatic test_async_reset;
        load = 1'b1; load_val = 4'd9;
        clk_edge();
        load = 1'b0; mode = 2'(CNT_WRAP); up = 1'b1; step = 3'd7; en = 1'b1;
        clk_edge();
        n_checks++;
        if (out !== 4'd6 || wrap_pulse !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset out=%0d wp=%0b exp out=6 wp=1", out, wrap_pulse);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out !== 4'd0 || wrap_pulse !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset out=%0d wp=%0b done=%0b exp out=0 wp=0 done=0", out, wrap_pulse, done);
        end
        en = 1'b0;
        clk_edge();
        rst = 1'b0;
        step = 3'd1; en = 1'b1;
        clk_edge();
        en = 1'b0;
        n_checks++;
        if (out !== 4'd1) begin
            n_errors++;
            $display("FAIL post_reset out=%0d exp=1", out);
        end
    endtask

`ifdef COUNT_PRESCALE_EN
    task automatic test_prescale;
        logic [3:0] exp_out[8] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
        clr = 1'b1;
        clk_edge();
        clr = 1'b0; mode = 2'(CNT_WRAP); up = 1'b1; step = 3'd1; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            clk_edge();
            n_checks++;
            if (out !== exp_out[i]) begin
                n_errors++;
                $display("FAIL prescale[%0d] out=%0d exp=%0d", i, out, exp_out[i]);
            end
        end
        // Two enabled cycles, a three-cycle gap, then the group completes.
        clk_edge();
        clk_edge();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            n_checks++;
            if (out !== 4'd2) begin
                n_errors++;
                $display("FAIL prescale_gap[%0d] out=%0d exp=2", i, out);
            end
        end
        en = 1'b1;
        clk_edge();
        n_checks++;
        if (out !== 4'd2) begin
            n_errors++;
            $display("FAIL prescale_resume3 out=%0d exp=2", out);
        end
        clk_edge();
        n_checks++;
        if (out !== 4'd3) begin
            n_errors++;
            $display("FAIL prescale_resume4 out=%0d exp=3", out);
        end
        en = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_oneshot();
        test_priority();
        test_back_to_back();
        test_async_reset();
`ifdef COUNT_PRESCALE_EN
        test_prescale();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
